// File: rtl/sym_gen_pkg.sv
// Shared constants for the symbol generator.
//   SYM_TABLE         : 16-entry code table (entry 0 in the low byte).
//   LFSR_MASK         : Galois feedback taps of the 16-bit random source.
//   LFSR_DEFAULT_SEED : value loaded at reset and in place of a zero seed,
//                       because an all-zero Galois LFSR never leaves zero.
//   sym_lookup(idx)   : returns the table entry for a 4-bit index.
package sym_gen_pkg;

    localparam int TABLE_DEPTH = 16;
    localparam int TABLE_W     = 8;

    localparam logic [15:0] LFSR_MASK         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Packed so that SYM_TABLE[i] is entry i; the literal lists entry 15 first.
    localparam logic [TABLE_DEPTH-1:0][TABLE_W-1:0] SYM_TABLE = {
        8'hED, 8'hF4, 8'hB3, 8'hF8, 8'h9D, 8'hE6, 8'hD5, 8'hDA,
        8'hBF, 8'hB6, 8'hE5, 8'h9E, 8'h89, 8'hD6, 8'hF1, 8'hEA
    };

    function automatic logic [TABLE_W-1:0] sym_lookup(input logic [3:0] idx);
        return SYM_TABLE[idx];
    endfunction

endpackage

// File: rtl/sym_gen_lfsr16.sv
// 16-bit right-shifting Galois LFSR with synchronous seed load.
//   Clk100M : clock
//   rst_n   : asynchronous active-low reset, value returns to the default seed
//   load    : replace this cycle's advance with the seed
//   seed    : seed value; zero is replaced by the default seed
//   value   : current LFSR state
module lfsr16
    import sym_gen_pkg::*;
(
    input  logic        Clk100M,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    always_ff @(posedge Clk100M or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            value <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
        end else begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/sym_gen_ctrl.sv
// Game symbol generator. While genSym is high it issues one symbol from the
// code table every max(symGenMax,1) cycles, flags it when its index equals
// targetIdx, optionally forbids back-to-back index repeats and forces the
// target after MAX_GAP-1 consecutive non-targets.
//   Clk100M, rst_n : clock, asynchronous active-low reset
//   genSym         : game period active; low clears interval, gap and repeat history
//   symGenMax      : cycles per symbol (0 behaves as 1)
//   targetIdx      : table index that counts as the target, sampled on fire
//   seedLoad, seed : reseed the LFSR on the next edge
//   clrCount       : clear specialCount (wins over a same-cycle increment)
//   generated      : one-cycle pulse, new symbol valid
//   special        : one-cycle pulse with generated, symbol is the target
//   generatedSym   : last symbol, held between pulses
//   symIdx         : table index of generatedSym
//   specialCount   : saturating count of targets issued
//
// Output protocol: generated is a valid-only strobe with no ready; the
// consumer must take generatedSym/symIdx/special in the cycle generated is
// high, as the producer never stalls.
module sym_gen_ctrl
    import sym_gen_pkg::*;
#(
    parameter int SYM_W     = 8,
    parameter int DEPTH     = 16,
    parameter int LFSR_W    = 16,
    parameter int MAX_GAP   = 12,
    parameter int NO_REPEAT = 1,
    parameter int CNT_W     = 8,
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              Clk100M,
    input  logic              rst_n,
    input  logic              genSym,
    input  logic [31:0]       symGenMax,
    input  logic [IDX_W-1:0]  targetIdx,
    input  logic              seedLoad,
    input  logic [LFSR_W-1:0] seed,
    input  logic              clrCount,
    output logic              generated,
    output logic              special,
    output logic [SYM_W-1:0]  generatedSym,
    output logic [IDX_W-1:0]  symIdx,
    output logic [CNT_W-1:0]  specialCount
);

    localparam int GAP_W = $clog2(MAX_GAP + 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((MAX_GAP > 0) ? MAX_GAP - 1 : 0);

    logic [LFSR_W-1:0] lfsr_value;
    logic [31:0]       cnt;
    logic [31:0]       max_m1;
    logic [GAP_W-1:0]  gap;
    logic              prev_valid;
    logic              fire;
    logic              forced;
    logic [IDX_W-1:0]  raw_idx;
    logic [IDX_W-1:0]  idx_sel;
    logic              is_special;
    logic              unused_lfsr_bits;

    lfsr16 u_lfsr (
        .Clk100M (Clk100M),
        .rst_n   (rst_n),
        .load    (seedLoad),
        .seed    (seed),
        .value   (lfsr_value)
    );

    // Only the low index bits pick the symbol; the rest just feed the shift.
    assign unused_lfsr_bits = ^lfsr_value[LFSR_W-1:IDX_W];

    // Comparing with >= (not ==) makes a symGenMax lowered mid-interval fire
    // at once instead of wrapping through 2^32 cycles.
    assign max_m1 = (symGenMax == 32'd0) ? 32'd0 : symGenMax - 32'd1;
    assign fire   = genSym && (cnt >= max_m1);

    always_comb begin
        raw_idx = lfsr_value[IDX_W-1:0];
        forced  = (MAX_GAP != 0) && (gap == GAP_LAST);
        idx_sel = raw_idx;
        // Forcing is checked first so a forced target may repeat the last index.
        if (forced) begin
            idx_sel = targetIdx;
        end else if ((NO_REPEAT != 0) && prev_valid && (raw_idx == symIdx)) begin
            idx_sel = raw_idx + IDX_W'(1); // DEPTH is a power of two: wraps mod DEPTH
        end
        is_special = (idx_sel == targetIdx);
    end

    always_ff @(posedge Clk100M or negedge rst_n) begin
        if (!rst_n) begin
            generated    <= 1'b0;
            special      <= 1'b0;
            generatedSym <= '1;
            symIdx       <= '0;
            specialCount <= '0;
            cnt          <= '0;
            gap          <= '0;
            prev_valid   <= 1'b0;
        end else begin
            generated <= fire;
            special   <= fire && is_special;

            if (!genSym) begin
                cnt        <= '0;
                gap        <= '0;
                prev_valid <= 1'b0;
            end else if (fire) begin
                cnt          <= '0;
                generatedSym <= SYM_W'(sym_lookup(4'(idx_sel)));
                symIdx       <= idx_sel;
                prev_valid   <= 1'b1;
                gap          <= is_special ? '0 : gap + GAP_W'(1);
            end else begin
                cnt <= cnt + 32'd1;
            end

            if (clrCount) begin
                specialCount <= '0;
            end else if (fire && is_special && (specialCount != '1)) begin
                specialCount <= specialCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/sym_gen_ctrl.md
Name: sym_gen_ctrl

Overview:
- Next-generation game symbol generator for the symbol-counter game.
- Emits one symbol from a parametrised code table every programmable interval while the game period is active.
- Flags the symbol when it matches a run-time-selectable target; can forbid back-to-back repeats and guarantees a maximum gap between targets.
- Owns its LFSR, which is seedable, and keeps a saturating count of targets issued. Sits between the game FSM and the display/score logic.

Parameters:
- SYM_W, 8: symbol width in bits.
- DEPTH, 16: table entries used; power of two, 2..16.
- LFSR_W, 16: random source width; fixed at 16 in this generation.
- MAX_GAP, 12: forces the target after MAX_GAP-1 consecutive non-target symbols; 0 disables forcing.
- NO_REPEAT, 1: 1 means an index never repeats on consecutive symbols.
- CNT_W, 8: width of the target counter.

Ports:
- Clk100M  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- genSym  in  1  game period active.
- symGenMax  in  32  cycles per symbol; 0 is treated as 1.
- targetIdx  in  IDX_W  table index that counts as special (IDX_W = clog2(DEPTH)).
- seedLoad  in  1  load the LFSR from seed next cycle.
- seed  in  LFSR_W  LFSR seed value.
- clrCount  in  1  synchronous clear of specialCount.
- generated  out  1  one-cycle pulse: new symbol valid.
- special  out  1  one-cycle pulse coincident with generated: symbol is the target.
- generatedSym  out  SYM_W  last symbol issued, held between pulses.
- symIdx  out  IDX_W  table index of generatedSym.
- specialCount  out  CNT_W  targets issued, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - generated=0, special=0, generatedSym=all ones, symIdx=0, specialCount=0.
  - Interval counter=0, gap counter=0, LFSR=16'hACE1, prevValid=0.
- LFSR: Galois, mask 16'hB400. Advances every cycle, regardless of genSym.
- Seeding: seedLoad=1 loads seed on the next edge, replacing the advance. A zero seed loads 16'hACE1.
- Interval counter (32-bit):
  - genSym=0: counter cleared to 0, no pulses, outputs held.
  - genSym=1: fire when cnt >= max(symGenMax,1)-1. On fire, cnt <= 0; otherwise cnt <= cnt+1.
  - The first symbol appears max(symGenMax,1) cycles after genSym rises. symGenMax<=1 fires every cycle.
- Index selection on fire, combinational from current state; registered outputs appear on the same edge as generated:
  - raw = lfsr[IDX_W-1:0].
  - If MAX_GAP!=0 and gap == MAX_GAP-1, idx = targetIdx (forced).
  - Else if NO_REPEAT and prevValid and raw == symIdx, idx = (raw+1) mod DEPTH.
  - Else idx = raw.
  - Forcing beats no-repeat: a forced target may repeat the previous index.
- Fire outputs:
  - generatedSym <= TABLE[idx]; symIdx <= idx; prevValid <= 1; generated <= 1.
  - special <= (idx == targetIdx), computed from the NEW index, never the previous symbol.
  - special=1: gap <= 0 and specialCount increments, saturating at all ones.
  - special=0: gap <= gap+1.
- Non-fire cycle: generated=0, special=0.
- genSym falling clears prevValid and gap. A new game starts fresh.
- clrCount coinciding with a special fire: clear wins, so specialCount=0.
- seedLoad coinciding with fire: fire uses the current LFSR; the seed takes effect afterwards.
- targetIdx may change at any time; it is sampled on the fire cycle.
- Reset mid-interval: everything returns to reset values immediately. No pulse is emitted during or on the edge leaving reset.

Decomposition:
- Package sym_gen_pkg:
  - SYM_TABLE[0..15] = EA F1 D6 89 9E E5 B6 BF DA D5 E6 9D F8 B3 F4 ED (hex, SYM_W=8), used entries 0..DEPTH-1.
  - LFSR_MASK=16'hB400, LFSR_DEFAULT_SEED=16'hACE1.
  - Function sym_lookup(idx).
- Sub-module lfsr16 (Clk100M, rst_n, load, seed, value) in its own file.

Test Plan:
- Reset release, genSym=1, symGenMax=4 -> generated pulses at cycles 4, 8, 12; symbol from TABLE[lfsr[3:0]]; special==(symIdx==targetIdx) on the same cycle.
- symGenMax=0 and symGenMax=1 -> generated high every cycle; no consecutive equal symIdx with NO_REPEAT=1.
- targetIdx=15, MAX_GAP=12, seed chosen to avoid 15 -> the 12th symbol is forced to index 15 (generatedSym=8'hED), special=1, gap reset.
- seed=0 with seedLoad, then two runs of 50 symbols from the same seed -> identical sequence starting from ACE1.
- specialCount: CNT_W=2, 5 specials -> saturates at 3; clrCount on a special fire -> 0.
- genSym low mid-interval, then high -> first pulse a full symGenMax later. rst_n pulsed low mid-run -> outputs at reset values asynchronously, generatedSym=8'hFF.
